// File: rtl/pipe_seq_ctrl.sv
// Fetch/stage sequencer for the 5-stage RV32I pipeline: PC, stage valids,
// boundary enables, bubble insertion and CSR/FENCE.I serialization.
module pipe_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_stall_req,
  input  logic             id_serialize_req,
  input  logic [31:0]      id_pc,
  input  logic             id_redirect,
  input  logic [31:0]      id_redirect_pc,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_redirect_pc,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic [31:0]      fetch_pc,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [1:0]       seq_state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, ISSUE = 2'd2, WAIT = 2'd3} seq_e;

  seq_e        state_q, state_d;
  logic [31:0] pc_d, resume_q, resume_d;
  // Boundary index: 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB
  logic [3:0]  vld_q, vld_d, vld_src, en, bub;
  logic        pc_moves, back_empty;
  logic        ex_redir, id_ser, id_redir, id_stall;

  assign ex_redir   = ex_redirect      & vld_q[1];
  assign id_ser     = id_serialize_req & vld_q[0];
  assign id_redir   = id_redirect      & vld_q[0];
  assign id_stall   = id_stall_req     & vld_q[0];
  assign back_empty = ~|vld_q[3:1];

  always_comb begin
    state_d  = state_q;
    pc_d     = fetch_pc;
    resume_d = resume_q;
    en       = '0;
    bub      = '0;
    pc_moves = 1'b0;
    if (!rst && !dcache_stall) begin
      en[3:2] = 2'b11;
      if (ex_redir) begin
        en[1:0]  = 2'b11;
        bub[1:0] = 2'b11;
        pc_d     = ex_redirect_pc;
        pc_moves = 1'b1;
        state_d  = RUN;
      end else begin
        case (state_q)
          DRAIN: begin
            en[1]  = 1'b1;
            bub[1] = 1'b1;
            if (back_empty) state_d = ISSUE;
          end
          ISSUE: begin
            en[1:0]  = 2'b11;
            bub[0]   = 1'b1;
            resume_d = id_pc;
            state_d  = WAIT;
          end
          WAIT: begin
            en[1]  = 1'b1;
            bub[1] = 1'b1;
            if (back_empty) begin
              pc_d     = resume_q + 32'd4;
              pc_moves = 1'b1;
              state_d  = RUN;
            end
          end
          default: begin
            if (id_ser) begin
              en[1]   = 1'b1;
              bub[1]  = 1'b1;
              state_d = DRAIN;
            end else if (id_redir) begin
              en[1:0]  = 2'b11;
              bub[0]   = 1'b1;
              pc_d     = id_redirect_pc;
              pc_moves = 1'b1;
            end else if (id_stall) begin
              en[1]  = 1'b1;
              bub[1] = 1'b1;
            end else if (icache_stall) begin
              en[1:0] = 2'b11;
              bub[0]  = 1'b1;
            end else begin
              en[1:0]  = 2'b11;
              pc_d     = fetch_pc + 32'd4;
              pc_moves = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // IF/ID source is always 1: synchronous imem returns the fetched word next cycle
  assign vld_src = {vld_q[2:0], 1'b1};
  assign vld_d   = (en & vld_src & ~bub) | (~en & vld_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      fetch_pc     <= RESET_PC;
      resume_q     <= '0;
      vld_q        <= '0;
      stall_cycles <= '0;
    end else begin
      state_q  <= state_d;
      fetch_pc <= pc_d;
      resume_q <= resume_d;
      vld_q    <= vld_d;
      if (!pc_moves && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  assign if_id_en  = en[0];
  assign id_ex_en  = en[1];
  assign ex_mem_en = en[2];
  assign mem_wb_en = en[3];
  assign id_valid  = vld_q[0];
  assign ex_valid  = vld_q[1];
  assign mem_valid = vld_q[2];
  assign wb_valid  = vld_q[3];
  assign seq_state = state_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: directed scenarios plus random traffic against a
// rule-level reference model of the sequencer.
module tb_pipe_seq_ctrl;
  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam int          CW     = 4;

  logic clk = 1'b0;
  logic rst, id_stall_req, id_serialize_req, id_redirect, ex_redirect;
  logic icache_stall, dcache_stall;
  logic [31:0] id_pc, id_redirect_pc, ex_redirect_pc, fetch_pc;
  logic if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic id_valid, ex_valid, mem_valid, wb_valid;
  logic [1:0] seq_state;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model state: stage valids in pipeline order (id, ex, mem, wb)
  logic [31:0] m_pc, m_res, n_pc, n_res;
  bit   [3:0]  m_v, n_v, e_en;
  int          m_st, n_st, m_cnt, n_cnt;

  pipe_seq_ctrl #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_stall_req(id_stall_req), .id_serialize_req(id_serialize_req), .id_pc(id_pc),
    .id_redirect(id_redirect), .id_redirect_pc(id_redirect_pc),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .fetch_pc(fetch_pc), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .seq_state(seq_state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_stall_req = 0; id_serialize_req = 0; id_redirect = 0; ex_redirect = 0;
    icache_stall = 0; dcache_stall = 0;
  endtask

  // One cycle of the priority rules, applied to the model's current state.
  task automatic model_eval();
    bit moved;
    n_pc = m_pc; n_v = m_v; n_st = m_st; n_res = m_res; n_cnt = m_cnt;
    e_en = '0; moved = 0;
    if (rst) begin
      n_pc = RST_PC; n_v = '0; n_st = 0; n_cnt = 0; n_res = '0;
    end else begin
      if (!dcache_stall) begin
        e_en[3:2] = 2'b11; n_v[3] = m_v[2]; n_v[2] = m_v[1];
        if (ex_redirect && m_v[1]) begin
          e_en[1:0] = 2'b11; n_v[1:0] = 2'b00; n_pc = ex_redirect_pc; n_st = 0; moved = 1;
        end else if (m_st == 1) begin
          e_en[1] = 1; n_v[1] = 0;
          if (m_v[3:1] == 0) n_st = 2;
        end else if (m_st == 2) begin
          e_en[1:0] = 2'b11; n_v[1] = m_v[0]; n_v[0] = 0; n_res = id_pc; n_st = 3;
        end else if (m_st == 3) begin
          e_en[1] = 1; n_v[1] = 0;
          if (m_v[3:1] == 0) begin n_pc = m_res + 4; n_st = 0; moved = 1; end
        end else if (id_serialize_req && m_v[0]) begin
          e_en[1] = 1; n_v[1] = 0; n_st = 1;
        end else if (id_redirect && m_v[0]) begin
          e_en[1:0] = 2'b11; n_v[1] = 1; n_v[0] = 0; n_pc = id_redirect_pc; moved = 1;
        end else if (id_stall_req && m_v[0]) begin
          e_en[1] = 1; n_v[1] = 0;
        end else if (icache_stall) begin
          e_en[1:0] = 2'b11; n_v[1] = m_v[0]; n_v[0] = 0;
        end else begin
          e_en = 4'hF; n_v[1] = m_v[0]; n_v[0] = 1; n_pc = m_pc + 4; moved = 1;
        end
      end
      if (!moved && m_cnt < (1 << CW) - 1) n_cnt = m_cnt + 1;
    end
  endtask

  // Inputs are set at the falling edge before calling; checks enables, then state.
  task automatic step();
    #1;
    model_eval();
    chk("if_id_en",  {31'b0, if_id_en},  {31'b0, e_en[0]});
    chk("id_ex_en",  {31'b0, id_ex_en},  {31'b0, e_en[1]});
    chk("ex_mem_en", {31'b0, ex_mem_en}, {31'b0, e_en[2]});
    chk("mem_wb_en", {31'b0, mem_wb_en}, {31'b0, e_en[3]});
    @(posedge clk);
    m_pc = n_pc; m_v = n_v; m_st = n_st; m_res = n_res; m_cnt = n_cnt;
    @(negedge clk);
    chk("fetch_pc",  fetch_pc, m_pc);
    chk("valids",    {28'b0, wb_valid, mem_valid, ex_valid, id_valid}, {28'b0, m_v});
    chk("seq_state", {30'b0, seq_state}, m_st[31:0]);
    chk("stall_cyc", {{(32-CW){1'b0}}, stall_cycles}, m_cnt[31:0]);
  endtask

  task automatic reset_fill(input int fill);
    idle(); rst = 1; step(); rst = 0;
    for (int i = 0; i < fill; i++) step();
  endtask

  initial begin
    int exp_st[9];
    exp_st = '{1, 1, 1, 2, 3, 3, 3, 3, 0};
    m_pc = '0; m_res = '0; m_v = '0; m_st = 0; m_cnt = 0;
    id_pc = '0; id_redirect_pc = '0; ex_redirect_pc = '0;
    idle(); rst = 1;
    step(); step();
    chk("rst_pc", fetch_pc, RST_PC);
    rst = 0;

    // Free run from reset
    step(); chk("run_pc1", fetch_pc, 32'h4000_0004); chk("run_id1", {31'b0, id_valid}, 32'd1);
    step(); chk("run_pc2", fetch_pc, 32'h4000_0008);
    step(); step(); chk("run_wb", {31'b0, wb_valid}, 32'd1);

    // Single-cycle load-use stall
    id_stall_req = 1; step(); id_stall_req = 0;
    chk("stall_cnt1", {{(32-CW){1'b0}}, stall_cycles}, 32'd1);
    chk("stall_exbub", {31'b0, ex_valid}, 32'd0);
    step();

    // EX redirect beats ID redirect and ID stall
    ex_redirect = 1; ex_redirect_pc = 32'h4000_0100;
    id_stall_req = 1; id_redirect = 1; id_redirect_pc = 32'h4000_0200;
    step(); idle();
    chk("exr_pc", fetch_pc, 32'h4000_0100);
    step(); step();

    // dcache stall freezes a pending EX redirect for 3 cycles
    reset_fill(4);
    dcache_stall = 1; ex_redirect = 1; ex_redirect_pc = 32'h4000_0300;
    repeat (3) step();
    chk("dc_cnt", {{(32-CW){1'b0}}, stall_cycles}, 32'd3);
    dcache_stall = 0; step(); idle();
    chk("dc_pc", fetch_pc, 32'h4000_0300);

    // Serialization of a CSR at 0x4000_0020 with a full back end
    reset_fill(4);
    id_serialize_req = 1; id_pc = 32'h4000_0020;
    for (int i = 0; i < 9; i++) begin
      step();
      id_serialize_req = 0;
      chk("ser_state", {30'b0, seq_state}, exp_st[i]);
    end
    chk("ser_pc", fetch_pc, 32'h4000_0024);
    step(); step();

    // Reset in the middle of DRAIN
    reset_fill(4);
    id_serialize_req = 1; step(); id_serialize_req = 0; step();
    rst = 1; step(); rst = 0;
    chk("rstd_state", {30'b0, seq_state}, 32'd0);
    chk("rstd_vld", {28'b0, wb_valid, mem_valid, ex_valid, id_valid}, 32'd0);
    chk("rstd_pc", fetch_pc, RST_PC);
    chk("rstd_cnt", {{(32-CW){1'b0}}, stall_cycles}, 32'd0);

    // Counter saturation
    reset_fill(2);
    dcache_stall = 1; repeat (20) step(); dcache_stall = 0;
    chk("sat_cnt", {{(32-CW){1'b0}}, stall_cycles}, 32'(((1 << CW) - 1)));

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst              = ($urandom_range(0, 99) == 0);
      dcache_stall     = ($urandom_range(0, 9) == 0);
      icache_stall     = ($urandom_range(0, 6) == 0);
      id_stall_req     = ($urandom_range(0, 6) == 0);
      id_serialize_req = ($urandom_range(0, 19) == 0);
      id_redirect      = ($urandom_range(0, 11) == 0);
      ex_redirect      = ($urandom_range(0, 15) == 0);
      id_pc            = $urandom;
      id_redirect_pc   = $urandom;
      ex_redirect_pc   = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
